mem_line_server: RTL

- Main-memory model that sits directly downstream of the instruction and data caches.
- Services whole-line refills (reads) and dirty-line write-backs (writes) with a fixed, parameterised latency.
- Arbitrates between the two cache miss ports round-robin and serves one request at a time.
- Backing storage is a line-wide array, optionally preloaded from a hex file for simulation.

---
 rtl/mem_line_server_pkg.sv | 18 +
 rtl/mem_line_server_arbiter.sv | 42 ++++
 rtl/mem_line_server.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_line_server_pkg.sv
// Shared constants and types for the main-memory line server and its arbiter.
package mem_line_server_pkg;

  localparam int CACHE_LINE_SIZE_BYTES = 64;
  localparam int CACHE_LINE_SIZE_BITS  = CACHE_LINE_SIZE_BYTES * 8;
  localparam int MEM_NUM_LINES         = 1024;
  localparam int MEM_LATENCY           = 5;
  localparam int ADDR_SIZE             = 32;

  typedef logic [CACHE_LINE_SIZE_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_line_server_arbiter.sv
// Two-port round-robin arbiter (icache / dcache); the pointer moves only on accept.
module mem_rr_arbiter
  import mem_line_server_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ic_req,
  input  logic dc_req,
  input  logic accept,
  output logic grant_ic,
  output logic any_req
);

  // 1 means the icache wins the next tie; reset favours the dcache.
  logic ptr_ic_r;

  // Pick a winner: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    grant_ic = 1'b0;
    if (ic_req && dc_req) begin
      grant_ic = ptr_ic_r;
    end else if (ic_req) begin
      grant_ic = 1'b1;
    end else begin
      grant_ic = 1'b0;
    end
  end

  assign any_req = ic_req | dc_req;

  // On accept the pointer is aimed at whichever port lost (or did not ask).
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_ic_r <= 1'b0;
    end else if (accept) begin
      ptr_ic_r <= ~grant_ic;
    end else begin
      ptr_ic_r <= ptr_ic_r;
    end
  end

endmodule

// File: rtl/mem_line_server.sv
// Fixed-latency line-wide main memory serving icache refills and dcache refills/write-backs.
module mem_line_server #(
  parameter int CACHE_LINE_SIZE_BYTES = mem_line_server_pkg::CACHE_LINE_SIZE_BYTES,
  parameter int CACHE_LINE_SIZE_BITS  = CACHE_LINE_SIZE_BYTES * 8,
  parameter int MEM_NUM_LINES         = mem_line_server_pkg::MEM_NUM_LINES,
  parameter int MEM_LATENCY           = mem_line_server_pkg::MEM_LATENCY,
  parameter int ADDR_SIZE             = mem_line_server_pkg::ADDR_SIZE
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ic_req_i,
  input  logic [ADDR_SIZE-1:0]            ic_addr_i,
  output logic [CACHE_LINE_SIZE_BITS-1:0] ic_data_o,
  output logic                            ic_valid_o,
  input  logic                            dc_req_i,
  input  logic                            dc_rd_wr_i,
  input  logic [ADDR_SIZE-1:0]            dc_addr_i,
  input  logic [CACHE_LINE_SIZE_BITS-1:0] dc_data_i,
  output logic [CACHE_LINE_SIZE_BITS-1:0] dc_data_o,
  output logic                            dc_valid_o
);
  import mem_line_server_pkg::*;

  localparam int OFF_W = $clog2(CACHE_LINE_SIZE_BYTES);
  localparam int IDX_W = $clog2(MEM_NUM_LINES);
  localparam int CNT_W = $clog2(MEM_LATENCY);
  // Accept cycle plus (MEM_LATENCY-1) BUSY cycles puts RESP exactly MEM_LATENCY after accept.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 2);

  logic [CACHE_LINE_SIZE_BITS-1:0] mem [MEM_NUM_LINES];

  mem_state_t                      state_r;
  logic [CNT_W-1:0]                cnt_r;
  logic                            grant_ic_r;
  logic                            rd_wr_r;
  logic [IDX_W-1:0]                idx_r;
  logic [CACHE_LINE_SIZE_BITS-1:0] wdata_r;

  logic grant_ic;
  logic any_req;
  logic accept;
  logic addr_unused;

  // Upper address bits alias and offset bits select bytes the caches handle themselves.
  assign addr_unused = ^{ic_addr_i[ADDR_SIZE-1:OFF_W+IDX_W], ic_addr_i[OFF_W-1:0],
                         dc_addr_i[ADDR_SIZE-1:OFF_W+IDX_W], dc_addr_i[OFF_W-1:0]};

  assign accept = (state_r == IDLE) && any_req;

  mem_rr_arbiter u_arb (
    .clk      (clk),
    .reset    (reset),
    .ic_req   (ic_req_i),
    .dc_req   (dc_req_i),
    .accept   (accept),
    .grant_ic (grant_ic),
    .any_req  (any_req)
  );

  // Request FSM: latch the granted request, count out the latency, pulse valid in RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      grant_ic_r <= 1'b0;
      rd_wr_r    <= 1'b0;
      idx_r      <= '0;
      wdata_r    <= '0;
      ic_valid_o <= 1'b0;
      dc_valid_o <= 1'b0;
      ic_data_o  <= '0;
      dc_data_o  <= '0;
    end else begin
      ic_valid_o <= 1'b0;
      dc_valid_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (any_req) begin
            state_r    <= BUSY;
            cnt_r      <= CNT_LOAD;
            grant_ic_r <= grant_ic;
            if (grant_ic) begin
              rd_wr_r <= 1'b0;
              idx_r   <= ic_addr_i[OFF_W +: IDX_W];
            end else begin
              rd_wr_r <= dc_rd_wr_i;
              idx_r   <= dc_addr_i[OFF_W +: IDX_W];
              wdata_r <= dc_data_i;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        BUSY: begin
          if (cnt_r == '0) begin
            state_r <= RESP;
            if (grant_ic_r) begin
              ic_valid_o <= 1'b1;
              ic_data_o  <= mem[idx_r];
            end else begin
              dc_valid_o <= 1'b1;
              if (!rd_wr_r) begin
                dc_data_o <= mem[idx_r];
              end else begin
                dc_data_o <= dc_data_o;
              end
            end
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Write-back commits at the end of RESP; a reset in that cycle suppresses it.
  always_ff @(posedge clk) begin
    if (!reset && (state_r == RESP) && !grant_ic_r && rd_wr_r) begin
      mem[idx_r] <= wdata_r;
    end
  end

endmodule
